fifo_rr_merge: RTL and testbench

//  Round-robin N:1 merger between FWFT FIFO read ports and one FIFO write port.

---
 rtl/fifo_rr_merge.sv | 181 ++++++++++++++++++
 tb/tb_fifo_rr_merge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_merge.sv
// fifo_rr_merge: round-robin N:1 merge of FWFT FIFO read ports into one FIFO write
// port, burst-held grants, one registered output stage. Option: FIFO_RR_MERGE_TAG_EN.

module fifo_rr_merge_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_W      = 2,
  parameter int IDX        = 0
) (
  input  logic                  pop_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  block_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  read_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic hit;

  assign hit    = pop_i && (sel_i == SEL_W'(IDX));
  assign read_o = hit && !block_i;
  // zero when not selected so the top can OR-reduce all lanes
  assign data_o = hit ? dout_i : '0;
endmodule

module fifo_rr_merge #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  localparam int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
`ifdef FIFO_RR_MERGE_TAG_EN
  localparam int OUT_W     = DATA_WIDTH + SEL_W
`else
  localparam int OUT_W     = DATA_WIDTH
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_empty_n,
  output logic [NUM_IN-1:0]            in_read,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [OUT_W-1:0]             out_din,
  output logic                         busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                            state_q, state_d;
  logic [SEL_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]                  grant_q, grant_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d, cnt_inc;
  logic                              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]                  out_din_q, out_din_d;
  logic                              accept, pop, cand_vld;
  logic [SEL_W-1:0]                  cand, pop_sel;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0] dout_arr, lane_data;
  logic [DATA_WIDTH-1:0]             sel_data;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    return (v == SEL_W'(NUM_IN - 1)) ? '0 : v + 1'b1;
  endfunction

  assign dout_arr = in_dout;
  assign accept   = !out_valid_q || out_full_n;
  assign cnt_inc  = cnt_q + 1'b1;

  // first non-empty requester starting at rr_ptr, wrapping NUM_IN-1 -> 0
  always_comb begin
    logic [SEL_W-1:0] idx;
    cand_vld = 1'b0;
    cand     = rr_ptr_q;
    idx      = rr_ptr_q;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!cand_vld && in_empty_n[idx]) begin
        cand_vld = 1'b1;
        cand     = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    pop_sel  = grant_q;
    case (state_q)
      IDLE: begin
        if (cand_vld && accept) begin
          pop     = 1'b1;
          pop_sel = cand;
          grant_d = cand;
          cnt_d   = CNT_W'(1);
          if (MAX_BURST == 1) rr_ptr_d = wrap_inc(cand);
          else                state_d  = BURST;
        end
      end
      BURST: begin
        if (!in_empty_n[grant_q]) begin
          // granted source ran dry: release, costs one bubble cycle
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(grant_q);
        end else if (accept) begin
          pop   = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(grant_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      fifo_rr_merge_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_W      (SEL_W),
        .IDX        (gi)
      ) u_lane (
        .pop_i   (pop),
        .sel_i   (pop_sel),
        .block_i (reset),
        .dout_i  (dout_arr[gi]),
        .read_o  (in_read[gi]),
        .data_o  (lane_data[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) sel_data = sel_data | lane_data[i];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_din_d   = out_din_q;
    if (pop) begin
      out_valid_d = 1'b1;
`ifdef FIFO_RR_MERGE_TAG_EN
      out_din_d   = {pop_sel, sel_data};
`else
      out_din_d   = sel_data;
`endif
    end else if (out_full_n) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_din_q   <= out_din_d;
    end
  end

  assign out_write = out_valid_q;
  assign out_din   = out_din_q;
  assign busy      = (state_q == BURST) || out_valid_q;

  a_read_onehot: assert property (@(posedge clk) $onehot0(in_read));
  a_cnt_bound:   assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_W'(MAX_BURST));
endmodule

// File: tb/tb_fifo_rr_merge.sv
// Directed bench for fifo_rr_merge: bench-side FWFT sources produce words {src, seq},
// a push log records downstream writes, and each test compares against hand-derived order.
`timescale 1ns/1ps
module tb_fifo_rr_merge;
  localparam int NUM_IN = 4;
  localparam int DW     = 32;
  localparam int SEL_W  = 2;
`ifdef FIFO_RR_MERGE_TAG_EN
  localparam int OUT_W  = DW + SEL_W;
`else
  localparam int OUT_W  = DW;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_IN-1:0]    in_empty_n, in_read;
  logic [NUM_IN*DW-1:0] in_dout;
  logic                 out_full_n = 1'b1;
  logic                 out_write, busy;
  logic [OUT_W-1:0]     out_din;

  int errors = 0;
  int checks = 0;
  int wr_cnt [NUM_IN] = '{default: 0};
  int rd_ptr [NUM_IN] = '{default: 0};
  logic tb_clr = 1'b0;
  logic beef   = 1'b0;
  logic [OUT_W-1:0] log_q [$];
  int log_cyc [$];
  int cyc = 0;
  int onehot_viol = 0;

  always #5 clk = ~clk;

  fifo_rr_merge #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_empty_n (in_empty_n),
    .in_read    (in_read),
    .in_dout    (in_dout),
    .out_full_n (out_full_n),
    .out_write  (out_write),
    .out_din    (out_din),
    .busy       (busy)
  );

  always_comb begin
    in_empty_n = '0;
    in_dout    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_empty_n[i]         = rd_ptr[i] < wr_cnt[i];
      in_dout[i*DW +: DW]   = {8'(i), 24'(rd_ptr[i])};
    end
    if (beef) in_dout[2*DW +: DW] = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ($countones(in_read) > 1) onehot_viol <= onehot_viol + 1;
    if (tb_clr) begin
      for (int i = 0; i < NUM_IN; i++) rd_ptr[i] <= 0;
      log_q.delete();
      log_cyc.delete();
    end else begin
      for (int i = 0; i < NUM_IN; i++) if (in_read[i]) rd_ptr[i] <= rd_ptr[i] + 1;
      if (!reset && out_write && out_full_n) begin
        log_q.push_back(out_din);
        log_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [OUT_W-1:0] exp_word(input int src, input int seq);
    logic [DW-1:0] d;
    d = {8'(src), 24'(seq)};
`ifdef FIFO_RR_MERGE_TAG_EN
    return {SEL_W'(src), d};
`else
    return d;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tb_clr = 1'b1; beef = 1'b0; out_full_n = 1'b1;
    for (int i = 0; i < NUM_IN; i++) wr_cnt[i] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0; tb_clr = 1'b0;
  endtask

  task automatic wait_pushes(input int n, input int budget, output bit ok);
    int b;
    b = 0; ok = 1'b1;
    while (log_q.size() < n) begin
      @(negedge clk);
      b++;
      if (b > budget) begin ok = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    wr_cnt[0] = 3;
    repeat (2) @(negedge clk);
    checks++; if (out_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", out_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_read !== '0) begin errors++; $display("FAIL reset_read: got %b expected 0", in_read); end
    checks++; if (out_din !== '0) begin errors++; $display("FAIL reset_din: got %h expected 0", out_din); end
    checks++; if (rd_ptr[0] != 0) begin errors++; $display("FAIL reset_nopop: got %0d pops expected 0", rd_ptr[0]); end
  endtask

  task automatic test_equal_share();
    bit ok;
    do_reset();
    for (int i = 0; i < NUM_IN; i++) wr_cnt[i] = 3;
    @(negedge clk);
    checks++; if (out_write !== 1'b1) begin errors++; $display("FAIL t1_latency: got %b expected 1", out_write); end
    wait_pushes(12, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_timeout: got %0d pushes expected 12", log_q.size()); end
    for (int k = 0; k < 12 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_word(k / 3, k % 3)) begin
        errors++; $display("FAIL t1_word%0d: got %h expected %h", k, log_q[k], exp_word(k / 3, k % 3));
      end
    end
    repeat (4) @(negedge clk);
    checks++; if (log_q.size() != 12) begin errors++; $display("FAIL t1_count: got %0d expected 12", log_q.size()); end
    if (log_cyc.size() >= 12) begin
      checks++;
      if (log_cyc[11] - log_cyc[0] != 14) begin
        errors++; $display("FAIL t1_span: got %0d cycles expected 14", log_cyc[11] - log_cyc[0]);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_burst_fairness();
    bit ok;
    int seg_src [6] = '{0, 2, 0, 2, 0, 2};
    int seg_len [6] = '{8, 8, 8, 8, 4, 4};
    int seq [NUM_IN] = '{default: 0};
    int k;
    do_reset();
    wr_cnt[0] = 20; wr_cnt[2] = 20;
    wait_pushes(40, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_timeout: got %0d pushes expected 40", log_q.size()); end
    k = 0;
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < seg_len[s]; j++) begin
        if (k < log_q.size()) begin
          checks++;
          if (log_q[k] !== exp_word(seg_src[s], seq[seg_src[s]])) begin
            errors++; $display("FAIL t2_word%0d: got %h expected %h", k, log_q[k], exp_word(seg_src[s], seq[seg_src[s]]));
          end
        end
        seq[seg_src[s]]++;
        k++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [OUT_W-1:0] held;
    do_reset();
    wr_cnt[0] = 8;
    wait_pushes(3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_start_timeout: got %0d pushes expected 3", log_q.size()); end
    out_full_n = 1'b0;
    #1;
    held = out_din;
    checks++; if (out_write !== 1'b1) begin errors++; $display("FAIL t3_write_pre: got %b expected 1", out_write); end
    checks++; if (in_read !== '0) begin errors++; $display("FAIL t3_read_pre: got %b expected 0", in_read); end
    repeat (5) begin
      @(negedge clk);
      checks++; if (out_write !== 1'b1) begin errors++; $display("FAIL t3_write_stall: got %b expected 1", out_write); end
      checks++; if (out_din !== held) begin errors++; $display("FAIL t3_din_stable: got %h expected %h", out_din, held); end
      checks++; if (in_read !== '0) begin errors++; $display("FAIL t3_read_stall: got %b expected 0", in_read); end
    end
    out_full_n = 1'b1;
    wait_pushes(8, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_timeout: got %0d pushes expected 8", log_q.size()); end
    repeat (4) @(negedge clk);
    checks++; if (log_q.size() != 8) begin errors++; $display("FAIL t3_count: got %0d expected 8", log_q.size()); end
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_word(0, k)) begin
        errors++; $display("FAIL t3_word%0d: got %h expected %h", k, log_q[k], exp_word(0, k));
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int exp_src [5] = '{2, 3, 0, 1, 0};
    int exp_seq [5] = '{0, 0, 0, 0, 1};
    do_reset();
    wr_cnt[2] = 1;
    wait_pushes(1, 10, ok);
    repeat (3) @(negedge clk);
    wr_cnt[3] = 1; wr_cnt[0] = 1;
    wait_pushes(3, 20, ok);
    repeat (3) @(negedge clk);
    wr_cnt[0] = 2; wr_cnt[1] = 1;
    wait_pushes(5, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_timeout: got %0d pushes expected 5", log_q.size()); end
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_word(exp_src[k], exp_seq[k])) begin
        errors++; $display("FAIL t4_word%0d: got %h expected %h", k, log_q[k], exp_word(exp_src[k], exp_seq[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int snap, nlog;
    do_reset();
    wr_cnt[1] = 8;
    wait_pushes(3, 20, ok);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_pre: got %b expected 1", busy); end
    snap = rd_ptr[1];
    reset = 1'b1;
    wr_cnt[0] = 2;
    #1;
    checks++; if (in_read !== '0) begin errors++; $display("FAIL t5_read_in_reset: got %b expected 0", in_read); end
    @(negedge clk);
    checks++; if (out_write !== 1'b0) begin errors++; $display("FAIL t5_write: got %b expected 0", out_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b expected 0", busy); end
    checks++; if (out_din !== '0) begin errors++; $display("FAIL t5_din: got %h expected 0", out_din); end
    checks++; if (rd_ptr[1] != snap) begin errors++; $display("FAIL t5_nopop: got %0d pops expected %0d", rd_ptr[1], snap); end
    reset = 1'b0;
    nlog = log_q.size();
    wait_pushes(nlog + 1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_timeout: got %0d pushes expected %0d", log_q.size(), nlog + 1); end
    if (ok) begin
      checks++;
      if (log_q[nlog] !== exp_word(0, 0)) begin
        errors++; $display("FAIL t5_restart: got %h expected %h", log_q[nlog], exp_word(0, 0));
      end
    end
  endtask

  task automatic test_tag();
    bit ok;
    logic [OUT_W-1:0] exp;
`ifdef FIFO_RR_MERGE_TAG_EN
    exp = {2'd2, 32'hDEADBEEF};
`else
    exp = 32'hDEADBEEF;
`endif
    do_reset();
    beef = 1'b1;
    wr_cnt[2] = 1;
    wait_pushes(1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_timeout: got %0d pushes expected 1", log_q.size()); end
    if (ok) begin
      checks++;
      if (log_q[0] !== exp) begin errors++; $display("FAIL t6_word: got %h expected %h", log_q[0], exp); end
    end
  endtask

  task automatic test_onehot();
    checks++;
    if (onehot_viol != 0) begin errors++; $display("FAIL onehot_read: got %0d violations expected 0", onehot_viol); end
  endtask

  initial begin
    test_reset();
    test_equal_share();
    test_burst_fairness();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_tag();
    test_onehot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
